// File: rtl/la_pkg.sv
// Shared definitions for the capture/transmit task slice: FSM state
// encoding of the sample uploader, the frame header byte, and the task
// handshake encoding used by the task dispatcher.
package la_pkg;

  // First byte of every upload frame.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Task handshake encoding, shared with the task dispatcher.
  typedef enum logic [1:0] {
    STATE_ACQ = 2'b01,
    STATE_TXD = 2'b10
  } task_state_t;

  // Uploader control states.
  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_ARM,
    S_WAIT_TX,
    S_FETCH,
    S_MEM,
    S_CSUM,
    S_DONE,
    S_RELEASE
  } up_state_t;

endpackage : la_pkg

// File: rtl/byte_checksum.sv
// 8-bit running sum (mod 256) of the sample bytes in one upload frame.
// clear has priority over add so a new frame always starts from zero.
module byte_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] value
);

  // Accumulate sample bytes; wrap-around is the intended mod-256 behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= 8'h00;
    end else if (clear) begin
      value <= 8'h00;
    end else if (add) begin
      value <= value + data;
    end
  end

endmodule : byte_checksum

// File: rtl/sample_uploader.sv
// Transmit-side responder of the capture/transmit handshake. Once granted
// the transmit slot it streams one frame to the UART: header byte, every
// sample of the buffer in ascending address order, then the checksum, and
// finally pulses done_txd to hand control back to acquisition.
module sample_uploader #(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] HDR_BYTE = la_pkg::HDR_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_txd,
  output logic              done_txd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

  import la_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  up_state_t         state_q;
  // One extra bit: the MSB sets once every sample has been sent, so the
  // counter can never wrap back to address 0 inside a frame.
  logic [ADDR_W:0]   cnt_q;
  // Set once the checksum byte has been loaded; selects DONE after WAIT_TX.
  logic              csum_sent_q;
  logic [7:0]        acc_value;
  logic              acc_clear;
  logic              acc_add;

  // NOTE: plain continuous assigns of registered state cannot infer latches;
  // any always_comb used instead would need a default for every output.
  assign acc_clear = (state_q == S_IDLE) && grant_txd;
  assign acc_add   = (state_q == S_MEM);

  byte_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .add   (acc_add),
    .data  (mem_data),
    .value (acc_value)
  );

  // Frame sequencer with registered strobes, address and UART byte.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it lives inside the clocked branch
    // and only takes effect at an edge; an abort mid-frame issues no done.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      csum_sent_q <= 1'b0;
      done_txd    <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      mem_addr    <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all
      // reads in this block see values from before the edge.
      tx_start <= 1'b0;
      done_txd <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // The grant is only looked at here; a drop mid-frame is ignored.
          if (grant_txd) begin
            cnt_q       <= '0;
            csum_sent_q <= 1'b0;
            mem_addr    <= '0;
            state_q     <= S_HDR;
          end
        end
        S_HDR: begin
          tx_data  <= HDR_BYTE;
          tx_start <= 1'b1;
          state_q  <= S_ARM;
        end
        S_ARM: begin
          // tx_busy only rises the cycle after the strobe, so skip one look.
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (!tx_busy) begin
            if (csum_sent_q) begin
              done_txd <= 1'b1;
              state_q  <= S_DONE;
            end else if (cnt_q[ADDR_W]) begin
              state_q <= S_CSUM;
            end else begin
              // Address is registered here so it is valid throughout FETCH.
              mem_addr <= cnt_q[ADDR_W-1:0];
              state_q  <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Buffer read latency: data appears one cycle after the address.
          state_q <= S_MEM;
        end
        S_MEM: begin
          tx_data  <= mem_data;
          tx_start <= 1'b1;
          cnt_q    <= cnt_q + CNT_ONE;
          state_q  <= S_ARM;
        end
        S_CSUM: begin
          tx_data     <= acc_value;
          tx_start    <= 1'b1;
          csum_sent_q <= 1'b1;
          state_q     <= S_ARM;
        end
        S_DONE: begin
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          // Wait for the grant to drop so a lingering grant cannot restart.
          if (!grant_txd) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule : sample_uploader

// File: tb/tb_sample_uploader.sv
// Self-checking bench for sample_uploader with a 4-sample buffer.
module tb_sample_uploader;

  localparam int ADDR_W = 2;
  localparam int NSAMP  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              grant_txd;
  logic              done_txd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  sample_uploader #(.ADDR_W(ADDR_W), .HDR_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_txd (grant_txd),
    .done_txd  (done_txd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample buffer model: synchronous read, one cycle latency.
  logic [7:0] mem [NSAMP];
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Captured frame and monitor counters.
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt = 0;
  int         viol     = 0;
  int         tim_err  = 0;

  // UART model: busy rises the cycle after tx_start and stays up for a
  // per-byte number of cycles.
  int busy_len = 10;
  int bp_idx   = -1;
  int bp_len   = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= ((cap_q.size() - 1) == bp_idx) ? bp_len : busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end
  end

  // Protocol monitor, sampled mid-cycle.
  logic       rst_prev = 1'b0;
  logic       busy_h1  = 1'b0;
  logic       busy_h2  = 1'b0;
  logic [7:0] data_prev;
  always @(negedge clk) begin
    if (rst_prev) begin
      if (tx_start) cap_q.push_back(tx_data);
      else if (tx_data !== data_prev) viol++;
      if (tx_start && tx_busy) viol++;
      if (done_txd) begin
        done_cnt++;
        if (!(busy_h1 == 1'b0 && busy_h2 == 1'b1)) tim_err++;
      end
    end
    busy_h2   = busy_h1;
    busy_h1   = tx_busy;
    data_prev = tx_data;
    rst_prev  = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the frame is the header, the samples in address order,
  // and the byte sum of the samples modulo 256.
  task automatic load_frame(input logic [NSAMP-1:0][7:0] m, input int blen);
    int sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NSAMP; i++) begin
      mem[i] = m[i];
      exp_q.push_back(m[i]);
      sum += int'(m[i]);
    end
    exp_q.push_back(8'(sum % 256));
    busy_len = blen;
    cap_q.delete();
    done_cnt = 0;
    viol     = 0;
    tim_err  = 0;
  endtask

  task automatic finish_frame(input string name, input int linger);
    for (int t = 0; t < 5000 && done_cnt == 0; t++) tick();
    for (int t = 0; t < linger; t++) tick();
    grant_txd = 1'b0;
    repeat (3) tick();
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " frame length"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
    check({name, " protocol"}, viol, 0);
    check({name, " done timing"}, tim_err, 0);
  endtask

  task automatic run_frame(input string name, input logic [NSAMP-1:0][7:0] m,
                           input int blen, input int linger);
    load_frame(m, blen);
    grant_txd = 1'b1;
    finish_frame(name, linger);
  endtask

  typedef struct {
    logic [NSAMP-1:0][7:0] m;
    int                    blen;
    logic [7:0]            csum;
  } vec_t;

  vec_t tbl [4];

  initial begin
    // Directed vectors with hand-computed checksums (element 0 is addr 0).
    tbl[0] = '{m: {8'hFF, 8'h03, 8'h02, 8'h01}, blen: 10, csum: 8'h05};
    tbl[1] = '{m: {8'h80, 8'h80, 8'h80, 8'h80}, blen: 10, csum: 8'h00};
    tbl[2] = '{m: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, blen: 1,  csum: 8'hFC};
    tbl[3] = '{m: {8'h00, 8'h00, 8'h00, 8'h00}, blen: 3,  csum: 8'h00};

    // Reset held 3 cycles with the grant already high.
    rst_n     = 1'b0;
    grant_txd = 1'b1;
    load_frame(tbl[0].m, tbl[0].blen);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset%0d tx_start", c), tx_start, 0);
      check($sformatf("reset%0d done_txd", c), done_txd, 0);
      check($sformatf("reset%0d tx_data", c), tx_data, 0);
      check($sformatf("reset%0d mem_addr", c), mem_addr, 0);
    end
    rst_n = 1'b1;
    tick();
    check("grant latency early", tx_start, 0);
    tick();
    check("grant latency strobe", tx_start, 1);
    check("grant latency header", tx_data, 8'hA5);

    // First frame with the grant lingering 50 cycles past done.
    finish_frame("frame0 linger", 50);
    check("frame0 csum", cap_q[NSAMP+1], tbl[0].csum);

    // Re-raised grant and the remaining table vectors.
    for (int i = 1; i < 4; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].m, tbl[i].blen, 0);
      check($sformatf("tbl%0d csum", i), cap_q[NSAMP+1], tbl[i].csum);
    end

    // Back-pressure: busy held 200 cycles on the second sample.
    bp_idx = 2;
    bp_len = 200;
    run_frame("backpressure", {8'h44, 8'h33, 8'h22, 8'h11}, 4, 0);
    bp_idx = -1;

    // Reset after the third byte aborts the frame without done.
    load_frame({8'h9A, 8'h78, 8'h56, 8'h34}, 6);
    grant_txd = 1'b1;
    for (int t = 0; t < 2000 && cap_q.size() < 3; t++) tick();
    check("midreset reached byte3", cap_q.size() >= 3, 1);
    rst_n     = 1'b0;
    grant_txd = 1'b0;
    tick();
    check("midreset tx_start", tx_start, 0);
    check("midreset tx_data", tx_data, 0);
    check("midreset mem_addr", mem_addr, 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("midreset no done", done_cnt, 0);
    run_frame("after reset", {8'hF0, 8'hE1, 8'hD2, 8'hC3}, 5, 0);

    // Randomized frames against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic [NSAMP-1:0][7:0] m;
      for (int i = 0; i < NSAMP; i++) m[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", r), m, int'($urandom_range(1, 12)),
                int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sample_uploader
